// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key sequencer: scan-code constants,
// one-hot FSM state encodings and the key-event record.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] EXT  = 4'b0010;
  localparam logic [3:0] BRK  = 4'b0100;
  localparam logic [3:0] EMIT = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = IDLE,
    ST_EXT  = EXT,
    ST_BRK  = BRK,
    ST_EMIT = EMIT
  } state_t;

  // "repeat" is a reserved word, so the repeat flag is called rpt
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       rpt;
  } key_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with occupancy count. Push and pop may occur in the same
// cycle; a push while full is accepted only when a pop frees a slot in that
// cycle. No write-to-read bypass: a byte written into an empty FIFO is not
// visible on rdata until the following cycle.
module ps2_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // storage array; contents need no reset, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 key sequencer: buffers raw scan-code bytes, strips E0/F0 prefixes,
// presents one key event at a time on a valid/ready interface, and tracks
// shift/ctrl state plus typematic repeats.
// Build option: PS2_TYPEMATIC_FILTER_EN drops repeat makes instead of
// presenting them (evt_repeat then stays 0).
//
// state | meaning
// IDLE  | waiting for the first byte of an event
// EXT   | E0 seen, waiting for F0 or the code byte
// BRK   | F0 seen, waiting for the code byte
// EMIT  | event held on evt_* until evt_ready
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_overflow,
  output logic [CNT_W-1:0] fifo_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             evt_repeat,
  output logic             shift_flag,
  output logic             ctrl_flag
);

  state_t     state;
  key_evt_t   evt;
  logic       ext_q;
  logic       brk_q;
  logic       last_valid;
  logic [7:0] last_code;
  logic       last_ext;

  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       capture;
  logic       last_hit;
  logic       cap_rpt;
  logic       present;

  assign pop      = !fifo_empty && (state != ST_EMIT);
  assign capture  = pop && !is_prefix(fifo_rdata);
  assign last_hit = last_valid && (last_code == fifo_rdata) && (last_ext == ext_q);
  assign cap_rpt  = !brk_q && last_hit;

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign present    = !cap_rpt;
  assign evt_repeat = 1'b0;
`else
  assign present    = 1'b1;
  assign evt_repeat = evt.rpt;
`endif

  assign evt_valid = (state == ST_EMIT);
  assign evt_code  = evt.code;
  assign evt_break = evt.brk;
  assign evt_ext   = evt.ext;

  ps2_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // sticky flag for a byte dropped at a full FIFO with no freeing pop
  always_ff @(posedge clk) begin
    if (rst)                                  rx_overflow <= 1'b0;
    else if (rx_valid && fifo_full && !pop)   rx_overflow <= 1'b1;
  end

  // prefix parser, event holding register, repeat and modifier tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      evt        <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      last_valid <= 1'b0;
      last_code  <= '0;
      last_ext   <= 1'b0;
      shift_flag <= 1'b0;
      ctrl_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_EXT, ST_BRK: begin
          if (capture) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (!brk_q) begin
              last_valid <= 1'b1;
              last_code  <= fifo_rdata;
              last_ext   <= ext_q;
            end else if (last_hit) begin
              last_valid <= 1'b0;
            end
            if (present) begin
              evt.code <= fifo_rdata;
              evt.brk  <= brk_q;
              evt.ext  <= ext_q;
              evt.rpt  <= cap_rpt && present;
              state    <= ST_EMIT;
            end else begin
              state    <= ST_IDLE;
            end
          end else if (pop && (fifo_rdata == SC_BRK)) begin
            // F0 from IDLE or EXT starts a break; a second F0 in BRK is harmless
            brk_q <= 1'b1;
            state <= ST_BRK;
          end else if (pop && (fifo_rdata == SC_EXT) && (state == ST_IDLE)) begin
            // E0 after F0 is ignored, and repeated E0 simply stays in EXT
            ext_q <= 1'b1;
            state <= ST_EXT;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            state <= ST_IDLE;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (((evt.code == SC_LSHIFT) || (evt.code == SC_RSHIFT)) && !evt.ext)
              shift_flag <= !evt.brk;
            if (evt.code == SC_CTRL)
              ctrl_flag <= !evt.brk;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
